// File: rtl/qpsk_stream_mapper_if.sv
// Stream bundle for qpsk_stream_mapper: word input handshake plus symbol output handshake.
// master is the mapper side; slave is the framer/filter side that drives words and sym_ready.
interface qpsk_stream_mapper_if #(
  parameter int unsigned WORD_W = 7,
  parameter int unsigned SYM_W  = 16
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  sym_re;
  logic [SYM_W-1:0]  sym_im;
  logic              sym_valid;
  logic              sym_ready;
  logic              sym_last;
  logic              sym_pilot;

  modport master (
    input  in_data, in_valid, sym_ready,
    output in_ready, sym_re, sym_im, sym_valid, sym_last, sym_pilot
  );

  modport slave (
    output in_data, in_valid, sym_ready,
    input  in_ready, sym_re, sym_im, sym_valid, sym_last, sym_pilot
  );
endinterface

// File: rtl/qpsk_stream_mapper.sv
// Sequential QPSK mapper: one I/Q symbol per output handshake, two bits per symbol, MSB pair first.
// Define QPSK_PILOT_EN to prefix every word with a (+AMP,+AMP) pilot symbol flagged by sym_pilot.
module qpsk_stream_mapper #(
  parameter int unsigned       WORD_W = 7,
  parameter int unsigned       SYM_W  = 16,
  parameter logic [SYM_W-1:0]  AMP    = 16'h16A1
) (
  input logic                  clk,
  input logic                  rst,
  qpsk_stream_mapper_if.master bus
);

  localparam int unsigned      NSYM    = (WORD_W + 1) / 2;
  localparam int unsigned      PW      = 2 * NSYM;
  localparam int unsigned      CntW    = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(NSYM - 1);
  localparam logic [SYM_W-1:0] NegAmp  = SYM_W'(0) - AMP;

`ifdef QPSK_PILOT_EN
  localparam bit PilotEn = 1'b1;
`else
  localparam bit PilotEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [PW-1:0]    sreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [SYM_W-1:0] re_q, im_q;
  logic             valid_q, last_q, pilot_q;

  logic [PW-1:0]    word_pad;
  logic [PW-1:0]    sreg_sh;
  logic [CntW-1:0]  cnt_inc;
  logic             word_xfer, sym_xfer;

  function automatic logic [SYM_W-1:0] level(input logic b);
    return b ? NegAmp : AMP;
  endfunction

  // Odd widths get a zero LSB pad so the word always splits into whole pairs.
  assign word_pad  = PW'(bus.in_data) << (PW - WORD_W);
  assign sreg_sh   = sreg_q << 2;
  assign cnt_inc   = cnt_q + CntW'(1);
  assign word_xfer = bus.in_valid & bus.in_ready;
  assign sym_xfer  = valid_q & bus.sym_ready;

  // in_ready opens on the last symbol's transfer cycle so words stream without a bubble.
  assign bus.in_ready = (state_q == StIdle) | ((state_q == StSend) & last_q & bus.sym_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pilot_q <= 1'b0;
    end else if (word_xfer) begin
      state_q <= StSend;
      sreg_q  <= word_pad;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      pilot_q <= PilotEn;
      re_q    <= PilotEn ? AMP : level(word_pad[PW-2]);
      im_q    <= PilotEn ? AMP : level(word_pad[PW-1]);
      last_q  <= !PilotEn && (LastCnt == '0);
    end else if (sym_xfer) begin
      if (last_q) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (pilot_q) begin
        // Pilot consumed: present the first data pair without shifting.
        pilot_q <= 1'b0;
        re_q    <= level(sreg_q[PW-2]);
        im_q    <= level(sreg_q[PW-1]);
        last_q  <= (LastCnt == '0);
      end else begin
        sreg_q  <= sreg_sh;
        cnt_q   <= cnt_inc;
        re_q    <= level(sreg_sh[PW-2]);
        im_q    <= level(sreg_sh[PW-1]);
        last_q  <= (cnt_inc == LastCnt);
      end
    end
  end

  assign bus.sym_re    = re_q;
  assign bus.sym_im    = im_q;
  assign bus.sym_valid = valid_q;
  assign bus.sym_last  = last_q;
  assign bus.sym_pilot = pilot_q;

endmodule

// File: tb/tb_qpsk_stream_mapper.sv
// Directed bench for qpsk_stream_mapper: default 7-bit build plus an 8-bit/12-bit instance.
// Expectations add the pilot symbol when QPSK_PILOT_EN is defined.
module tb_qpsk_stream_mapper;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  qpsk_stream_mapper_if #(.WORD_W(7), .SYM_W(16)) bus_a ();
  qpsk_stream_mapper_if #(.WORD_W(8), .SYM_W(12)) bus_b ();

  qpsk_stream_mapper dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  qpsk_stream_mapper #(
    .WORD_W (8),
    .SYM_W  (12),
    .AMP    (12'h2D4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One symbol on the next falling edge; sym_ready is assumed high, so in_ready tracks last.
  task automatic exp_sym(input string tag, input bit use_b, input logic [15:0] re,
                         input logic [15:0] im, input logic last, input logic pilot);
    @(negedge clk);
    if (use_b) begin
      check({tag, " valid"}, 32'(bus_b.sym_valid), 32'(1));
      check({tag, " re"},    32'(bus_b.sym_re),    32'(re));
      check({tag, " im"},    32'(bus_b.sym_im),    32'(im));
      check({tag, " last"},  32'(bus_b.sym_last),  32'(last));
      check({tag, " pilot"}, 32'(bus_b.sym_pilot), 32'(pilot));
      check({tag, " ready"}, 32'(bus_b.in_ready),  32'(last));
    end else begin
      check({tag, " valid"}, 32'(bus_a.sym_valid), 32'(1));
      check({tag, " re"},    32'(bus_a.sym_re),    32'(re));
      check({tag, " im"},    32'(bus_a.sym_im),    32'(im));
      check({tag, " last"},  32'(bus_a.sym_last),  32'(last));
      check({tag, " pilot"}, 32'(bus_a.sym_pilot), 32'(pilot));
      check({tag, " ready"}, 32'(bus_a.in_ready),  32'(last));
    end
  endtask

  task automatic exp_pilot(input string tag, input bit use_b);
`ifdef QPSK_PILOT_EN
    exp_sym(tag, use_b, use_b ? 16'h02D4 : 16'h16A1, use_b ? 16'h02D4 : 16'h16A1, 1'b0, 1'b1);
`else
    if (use_b && tag == "") $display("empty tag");
`endif
  endtask

  task automatic accept_a(input string tag, input logic [6:0] d);
    @(negedge clk);
    bus_a.in_data  = d;
    bus_a.in_valid = 1'b1;
    check({tag, " accept ready"}, 32'(bus_a.in_ready), 32'(1));
    @(posedge clk);
    #1 bus_a.in_valid = 1'b0;
  endtask

  task automatic exp_idle_a(input string tag);
    @(negedge clk);
    check({tag, " idle valid"}, 32'(bus_a.sym_valid), 32'(0));
    check({tag, " idle ready"}, 32'(bus_a.in_ready),  32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus_a.in_data   = '0;
    bus_a.in_valid  = 1'b0;
    bus_a.sym_ready = 1'b1;
    bus_b.in_data   = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.sym_ready = 1'b1;

    // Reset state
    #12;
    check("rst valid", 32'(bus_a.sym_valid), 32'(0));
    check("rst re",    32'(bus_a.sym_re),    32'(0));
    check("rst im",    32'(bus_a.sym_im),    32'(0));
    check("rst last",  32'(bus_a.sym_last),  32'(0));
    check("rst pilot", 32'(bus_a.sym_pilot), 32'(0));
    check("rst ready", 32'(bus_a.in_ready),  32'(1));
    @(negedge clk);
    rst = 1'b0;

    // Single word, latency 1
    accept_a("t1", 7'b0011011);
    exp_pilot("t1 pilot", 1'b0);
    exp_sym("t1 s0", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t1 s1", 1'b0, 16'hE95F, 16'hE95F, 1'b0, 1'b0);
    exp_sym("t1 s2", 1'b0, 16'hE95F, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t1 s3", 1'b0, 16'h16A1, 16'hE95F, 1'b1, 1'b0);
    exp_idle_a("t1");

    // Back-to-back words with in_valid held
    bus_a.in_data  = 7'h00;
    bus_a.in_valid = 1'b1;
    check("t2 accept ready", 32'(bus_a.in_ready), 32'(1));
    @(posedge clk);
    #1 bus_a.in_data = 7'h7F;
    exp_pilot("t2 w0 pilot", 1'b0);
    exp_sym("t2 w0 s0", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t2 w0 s1", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t2 w0 s2", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t2 w0 s3", 1'b0, 16'h16A1, 16'h16A1, 1'b1, 1'b0);
    @(posedge clk);
    #1 bus_a.in_valid = 1'b0;
    exp_pilot("t2 w1 pilot", 1'b0);
    exp_sym("t2 w1 s0", 1'b0, 16'hE95F, 16'hE95F, 1'b0, 1'b0);
    exp_sym("t2 w1 s1", 1'b0, 16'hE95F, 16'hE95F, 1'b0, 1'b0);
    exp_sym("t2 w1 s2", 1'b0, 16'hE95F, 16'hE95F, 1'b0, 1'b0);
    exp_sym("t2 w1 s3", 1'b0, 16'h16A1, 16'hE95F, 1'b1, 1'b0);
    exp_idle_a("t2");

    // Back-pressure on the second data symbol; a pending word must be ignored
    accept_a("t3", 7'b0011011);
    exp_pilot("t3 pilot", 1'b0);
    exp_sym("t3 s0", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t3 s1", 1'b0, 16'hE95F, 16'hE95F, 1'b0, 1'b0);
    bus_a.sym_ready = 1'b0;
    bus_a.in_data   = 7'h7F;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3 hold valid", 32'(bus_a.sym_valid), 32'(1));
      check("t3 hold re",    32'(bus_a.sym_re),    32'hE95F);
      check("t3 hold im",    32'(bus_a.sym_im),    32'hE95F);
      check("t3 hold last",  32'(bus_a.sym_last),  32'(0));
      check("t3 hold ready", 32'(bus_a.in_ready),  32'(0));
    end
    bus_a.sym_ready = 1'b1;
    bus_a.in_valid  = 1'b0;
    exp_sym("t3 s2", 1'b0, 16'hE95F, 16'h16A1, 1'b0, 1'b0);
    exp_sym("t3 s3", 1'b0, 16'h16A1, 16'hE95F, 1'b1, 1'b0);
    exp_idle_a("t3");

    // Asynchronous reset during the second data symbol
    accept_a("t4", 7'b0011011);
    exp_pilot("t4 pilot", 1'b0);
    exp_sym("t4 s0", 1'b0, 16'h16A1, 16'h16A1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4 s1 valid", 32'(bus_a.sym_valid), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("t4 async valid", 32'(bus_a.sym_valid), 32'(0));
    check("t4 async ready", 32'(bus_a.in_ready),  32'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_idle_a("t4 post");

    // 8-bit word, 12-bit samples, amplitude 0x2D4
    @(negedge clk);
    bus_b.in_data  = 8'hB4;
    bus_b.in_valid = 1'b1;
    check("t5 accept ready", 32'(bus_b.in_ready), 32'(1));
    @(posedge clk);
    #1 bus_b.in_valid = 1'b0;
    exp_pilot("t5 pilot", 1'b1);
    exp_sym("t5 s0", 1'b1, 16'h02D4, 16'h0D2C, 1'b0, 1'b0);
    exp_sym("t5 s1", 1'b1, 16'h0D2C, 16'h0D2C, 1'b0, 1'b0);
    exp_sym("t5 s2", 1'b1, 16'h0D2C, 16'h02D4, 1'b0, 1'b0);
    exp_sym("t5 s3", 1'b1, 16'h02D4, 16'h02D4, 1'b1, 1'b0);
    @(negedge clk);
    check("t5 idle valid", 32'(bus_b.sym_valid), 32'(0));
    check("t5 idle ready", 32'(bus_b.in_ready),  32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
